// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types.
// Register-file index and related widths used across pipeline blocks.
package cpu_types_pkg;

  localparam int unsigned RegIdxWidth = 5;

  typedef logic [RegIdxWidth-1:0] regbits_t;

endpackage

// File: rtl/pipeline_ctrl_pkg.sv
// Types and helpers for the pipeline hazard controller.
// The state encoding is visible on the state output, so the values are fixed.
package pipeline_ctrl_pkg;

  localparam int unsigned CntWidth = 16;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StDwait  = 2'b01,
    StHalted = 2'b10
  } pctrl_state_t;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  function automatic logic load_use(logic dren, cpu_types_pkg::regbits_t wsel,
                                    cpu_types_pkg::regbits_t rs,
                                    cpu_types_pkg::regbits_t rt);
    return dren && (wsel != '0) && ((wsel == rs) || (wsel == rt));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous enable and asynchronous clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_en,
  output logic [Width-1:0] o_count
);

  logic [Width-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory freeze, halt, branch flush, load-use and
// fetch-miss stalls. A latch being flushed always has its enable deasserted.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dREN,
  input  logic        exmem_dWEN,
  input  logic        exmem_halt,
  input  logic        br_taken,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_wsel,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        halt,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  pctrl_state_t r_state, w_next_state;
  logic w_dstall, w_loaduse, w_flush_evt, w_stall_evt;

  assign w_dstall  = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign w_loaduse = load_use(idex_dREN, idex_wsel, ifid_rs, ifid_rt);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= StRun;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    exmem_flush  = 1'b0;
    memwb_en     = 1'b0;
    memwb_flush  = 1'b0;
    w_flush_evt  = 1'b0;
    w_next_state = r_state;
    if (nRST) begin
      unique case (r_state)
        StRun, StDwait: begin
          if (w_dstall) begin
            w_next_state = StDwait;
          end else begin
            w_next_state = StRun;
            if (exmem_halt) begin
              ifid_flush   = 1'b1;
              idex_flush   = 1'b1;
              exmem_flush  = 1'b1;
              memwb_en     = 1'b1;
              w_next_state = StHalted;
            end else if (br_taken) begin
              pc_en       = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              memwb_en    = 1'b1;
              w_flush_evt = 1'b1;
            end else if (w_loaduse) begin
              // Hold PC and IF/ID, inject a bubble into EX.
              idex_flush = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
            end else if (!ihit) begin
              ifid_flush = 1'b1;
              idex_en    = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
            end else begin
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
            end
          end
        end
        StHalted: w_next_state = StHalted;
        default:  w_next_state = StRun;
      endcase
    end
  end

  assign halt        = (r_state == StHalted);
  assign state       = r_state;
  assign w_stall_evt = (r_state != StHalted) & ~pc_en;

  sat_counter #(
    .Width(CntWidth)
  ) u_stall_cnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .i_en   (w_stall_evt),
    .o_count(stall_cnt)
  );

  sat_counter #(
    .Width(CntWidth)
  ) u_flush_cnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .i_en   (w_flush_evt),
    .o_count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes per-cycle expectations from a
// rule-level reference model, and a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

  logic        CLK, nRST, ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, br_taken, idex_dREN;
  logic [4:0]  idex_wsel, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_ctrl dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .dhit       (dhit),
    .exmem_dREN (exmem_dREN),
    .exmem_dWEN (exmem_dWEN),
    .exmem_halt (exmem_halt),
    .br_taken   (br_taken),
    .idex_dREN  (idex_dREN),
    .idex_wsel  (idex_wsel),
    .ifid_rs    (ifid_rs),
    .ifid_rt    (ifid_rt),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .idex_en    (idex_en),
    .idex_flush (idex_flush),
    .exmem_en   (exmem_en),
    .exmem_flush(exmem_flush),
    .memwb_en   (memwb_en),
    .memwb_flush(memwb_flush),
    .halt       (halt),
    .state      (state),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic       rst_n;
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       hlt;
    logic       br;
    logic       idren;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
  } stim_t;

  typedef struct packed {
    logic [8:0]  ctrl;  // {pc_en, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl}
    logic        hlt;
    logic [1:0]  st;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  localparam int ActReset = 0, ActHaltedIdle = 1, ActFreeze = 2, ActHalt = 3;
  localparam int ActBranch = 4, ActLoadUse = 5, ActFetchMiss = 6, ActRun = 7;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_state = 0;  // 0 run, 1 waiting on data, 2 halted
  int   m_scnt = 0;
  int   m_fcnt = 0;

  function automatic int classify(stim_t s, int st);
    if (!s.rst_n) return ActReset;
    if (st == 2) return ActHaltedIdle;
    if ((s.dren || s.dwen) && !s.dhit) return ActFreeze;
    if (s.hlt) return ActHalt;
    if (s.br) return ActBranch;
    if (s.idren && s.wsel != 0 && (s.wsel == s.rs || s.wsel == s.rt)) return ActLoadUse;
    if (!s.ihit) return ActFetchMiss;
    return ActRun;
  endfunction

  function automatic logic [8:0] ctrl_of(int act);
    case (act)
      ActHalt:      return 9'b0_01_01_01_10;
      ActBranch:    return 9'b1_01_01_01_10;
      ActLoadUse:   return 9'b0_00_01_10_10;
      ActFetchMiss: return 9'b0_01_10_10_10;
      ActRun:       return 9'b1_10_10_10_10;
      default:      return 9'b0_00_00_00_00;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.ihit  = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n = ($urandom_range(0, 59) != 0);
    s.ihit  = ($urandom_range(0, 4) != 0);
    s.dhit  = ($urandom_range(0, 2) != 0);
    s.dren  = ($urandom_range(0, 3) == 0);
    s.dwen  = ($urandom_range(0, 4) == 0);
    s.hlt   = ($urandom_range(0, 79) == 0);
    s.br    = ($urandom_range(0, 5) == 0);
    s.idren = ($urandom_range(0, 2) == 0);
    s.wsel  = 5'($urandom_range(0, 3));
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic step(input stim_t s);
    int   act;
    exp_t e;
    nRST       = s.rst_n;
    ihit       = s.ihit;
    dhit       = s.dhit;
    exmem_dREN = s.dren;
    exmem_dWEN = s.dwen;
    exmem_halt = s.hlt;
    br_taken   = s.br;
    idex_dREN  = s.idren;
    idex_wsel  = s.wsel;
    ifid_rs    = s.rs;
    ifid_rt    = s.rt;
    if (!s.rst_n) begin
      m_state = 0;
      m_scnt  = 0;
      m_fcnt  = 0;
    end
    act    = classify(s, m_state);
    e.ctrl = ctrl_of(act);
    e.hlt  = (m_state == 2);
    e.st   = 2'(m_state);
    e.scnt = 16'(m_scnt);
    e.fcnt = 16'(m_fcnt);
    q.push_back(e);
    @(posedge CLK);
    if (act != ActReset) begin
      if (m_state != 2 && !e.ctrl[8] && m_scnt < 65535) m_scnt++;
      if (act == ActBranch && m_fcnt < 65535) m_fcnt++;
      if (act == ActFreeze) m_state = 1;
      else if (act == ActHalt || act == ActHaltedIdle) m_state = 2;
      else m_state = 0;
    end
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ctrl", int'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                            exmem_flush, memwb_en, memwb_flush}), int'(e.ctrl));
        check("halt", int'(halt), int'(e.hlt));
        check("state", int'(state), int'(e.st));
        check("stall_cnt", int'(stall_cnt), int'(e.scnt));
        check("flush_cnt", int'(flush_cnt), int'(e.fcnt));
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL timeout: run did not complete, got incomplete want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    stim_t s;
    nRST = 1'b1;
    {ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, br_taken, idex_dREN} = '0;
    idex_wsel = '0;
    ifid_rs   = '0;
    ifid_rt   = '0;
    @(posedge CLK);
    #1;
    s = idle();
    s.rst_n = 1'b0;
    step(s);
    step(s);
    step(idle());

    // Data-miss freeze for three cycles, then the hit releases it.
    s = idle();
    s.dren = 1'b1;
    repeat (3) step(s);
    s.dhit = 1'b1;
    step(s);
    step(idle());

    // Load-use on rt, then the same pattern against register 0.
    s = idle();
    s.idren = 1'b1;
    s.wsel  = 5'd5;
    s.rt    = 5'd5;
    step(s);
    s.wsel = 5'd0;
    s.rt   = 5'd0;
    step(s);

    // Branch outranks a simultaneous load-use and fetch miss.
    s = idle();
    s.br    = 1'b1;
    s.idren = 1'b1;
    s.wsel  = 5'd7;
    s.rs    = 5'd7;
    s.ihit  = 1'b0;
    step(s);
    step(idle());

    // Halt is sticky until reset, whatever the inputs do.
    s = idle();
    s.hlt = 1'b1;
    step(s);
    for (int i = 0; i < 6; i++) begin
      s = rnd();
      s.rst_n = 1'b1;
      step(s);
    end
    s = idle();
    s.rst_n = 1'b0;
    step(s);
    step(idle());

    for (int i = 0; i < 2000; i++) step(rnd());

    // Saturate the stall counter with a long memory freeze.
    s = idle();
    s.rst_n = 1'b0;
    step(s);
    s = idle();
    s.dren = 1'b1;
    for (int i = 0; i < 65540; i++) step(s);
    s.dhit = 1'b1;
    step(s);
    step(idle());

    @(negedge CLK);
    #1;
    check("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
